// File: rtl/b1_pkg.sv
// Shared constants, state encoding and field-size helpers for the B1 measurement reporter.
package b1_pkg;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    IDLE, SYNC0, SYNC1, SEQ, FLAGS, CHAN, CSUM
  } state_t;

  function automatic int bytes_of(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int ch_bytes(input int nco_w, input int phs_w, input int acc_w);
    return 2 * bytes_of(nco_w) + bytes_of(phs_w) + 2 * bytes_of(acc_w);
  endfunction

  localparam int CH_BYTES = ch_bytes(32, 12, 24);

endpackage

// File: rtl/b1_pps_sync.sv
// Two-flop synchroniser plus rising-edge detector; the strobe is registered.
module b1_pps_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      rise <= 1'b0;
    end else begin
      sr   <= {sr[1:0], din};
      rise <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/b1_meas_frame.sv
// PPS-triggered snapshot of all tracking channels, serialised as a framed,
// sequence-numbered, XOR-checksummed byte stream on a valid/ready port.
module b1_meas_frame
  import b1_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int NCO_W  = 32,
  parameter int PHS_W  = 12,
  parameter int ACC_W  = 24
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     rx_pps,
  input  logic [NUM_CH*NCO_W-1:0]  rx_car_nco,
  input  logic [NUM_CH*NCO_W-1:0]  rx_prn_nco,
  input  logic [NUM_CH*PHS_W-1:0]  rx_prn_phs,
  input  logic [NUM_CH*ACC_W-1:0]  rx_acc_real,
  input  logic [NUM_CH*ACC_W-1:0]  rx_acc_imag,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_busy,
  output logic                     tx_ovr
);

  localparam int NCO_PW  = 8 * bytes_of(NCO_W);
  localparam int PHS_PW  = 8 * bytes_of(PHS_W);
  localparam int ACC_PW  = 8 * bytes_of(ACC_W);
  localparam int CH_B    = ch_bytes(NCO_W, PHS_W, ACC_W);
  localparam int CH_BITS = 8 * CH_B;
  localparam int CI_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W    = $clog2(CH_B);

  localparam logic [CI_W-1:0] LAST_CH = CI_W'(NUM_CH - 1);
  localparam logic [BI_W-1:0] LAST_BI = BI_W'(CH_B - 1);

  logic pps_rise;

  b1_pps_sync u_pps_sync (
    .clk   (rx_clk),
    .rst_n (rx_rst_n),
    .din   (rx_pps),
    .rise  (pps_rise)
  );

  state_t          state, state_n;
  logic [CI_W-1:0] ch, ch_n;
  logic [BI_W-1:0] bi, bi_n;
  logic            snap_en;
  logic            hs, load;
  logic [7:0]      seq, csum, byte_n, chan_byte;
  logic            ovr_flag;

  logic [NUM_CH-1:0][NCO_W-1:0] snap_car, snap_prn;
  logic [NUM_CH-1:0][PHS_W-1:0] snap_phs;
  logic [NUM_CH-1:0][ACC_W-1:0] snap_re, snap_im;
  logic [NUM_CH-1:0][CH_BITS-1:0] chan_vec;

  assign hs   = tx_valid & tx_ready;
  // The output register refills on every handshake, or on the first cycle of a frame.
  assign load = hs | (~tx_valid & (state != IDLE));

  // A PPS edge landing on the CSUM handshake starts the next frame instead of overrunning.
  assign tx_ovr = pps_rise & (state != IDLE) & ~((state == CSUM) & hs);

  // Each channel laid out MSB first as its on-wire byte sequence.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [ACC_W-1:0] re_s, im_s;
    assign re_s = snap_re[c];
    assign im_s = snap_im[c];
    assign chan_vec[c] = {NCO_PW'(snap_car[c]), NCO_PW'(snap_prn[c]),
                          PHS_PW'(snap_phs[c]), ACC_PW'(re_s), ACC_PW'(im_s)};
  end

  assign chan_byte = chan_vec[ch_n][(CH_B - 1 - int'(bi_n)) * 8 +: 8];

  always_comb begin
    state_n = state;
    ch_n    = ch;
    bi_n    = bi;
    snap_en = 1'b0;
    case (state)
      IDLE:  if (pps_rise) begin state_n = SYNC0; snap_en = 1'b1; end
      SYNC0: if (hs) state_n = SYNC1;
      SYNC1: if (hs) state_n = SEQ;
      SEQ:   if (hs) state_n = FLAGS;
      FLAGS: if (hs) begin state_n = CHAN; ch_n = '0; bi_n = '0; end
      CHAN: if (hs) begin
        if (bi == LAST_BI) begin
          bi_n = '0;
          if (ch == LAST_CH) state_n = CSUM;
          else               ch_n = ch + 1'b1;
        end else begin
          bi_n = bi + 1'b1;
        end
      end
      CSUM: if (hs) begin
        if (pps_rise) begin state_n = SYNC0; snap_en = 1'b1; end
        else          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    byte_n = 8'h00;
    case (state_n)
      SYNC0:   byte_n = SYNC0_BYTE;
      SYNC1:   byte_n = SYNC1_BYTE;
      SEQ:     byte_n = seq;
      FLAGS:   byte_n = {7'(NUM_CH), ovr_flag};
      CHAN:    byte_n = chan_byte;
      CSUM:    byte_n = csum;
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state <= IDLE;
      ch    <= '0;
      bi    <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      bi    <= bi_n;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      tx_busy  <= 1'b0;
      seq      <= 8'h00;
      csum     <= 8'h00;
      ovr_flag <= 1'b0;
      snap_car <= '0;
      snap_prn <= '0;
      snap_phs <= '0;
      snap_re  <= '0;
      snap_im  <= '0;
    end else begin
      if (snap_en) begin
        snap_car <= rx_car_nco;
        snap_prn <= rx_prn_nco;
        snap_phs <= rx_prn_phs;
        snap_re  <= rx_acc_real;
        snap_im  <= rx_acc_imag;
      end
      if (load) begin
        tx_valid <= (state_n != IDLE);
        tx_busy  <= (state_n != IDLE);
        tx_data  <= byte_n;
        if (state_n == SEQ)                          csum <= byte_n;
        else if (state_n == FLAGS || state_n == CHAN) csum <= csum ^ byte_n;
      end
      if (hs && state == CSUM) seq <= seq + 8'd1;
      // Only clear the overrun that was actually reported in the accepted FLAGS byte.
      ovr_flag <= tx_ovr | (ovr_flag & ~(hs & (state == FLAGS) & tx_data[0]));
    end
  end

endmodule

// File: tb/tb_b1_meas_frame.sv
// Bench for b1_meas_frame: directed table rows, timing sequences and random
// backpressure frames checked against a byte-level frame model.
module tb_b1_meas_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rx_rst_n, rx_pps, tx_ready, rx_pps5;
  logic [63:0] car, prn;
  logic [23:0] phs;
  logic [47:0] re, im;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_busy, tx_ovr;

  logic [159:0] car5, prn5;
  logic [64:0]  phs5;
  logic [99:0]  re5, im5;
  logic [7:0]   tx_data5;
  logic         tx_valid5, tx_busy5, tx_ovr5;

  b1_meas_frame dut (
    .rx_clk(clk), .rx_rst_n(rx_rst_n), .rx_pps(rx_pps),
    .rx_car_nco(car), .rx_prn_nco(prn), .rx_prn_phs(phs),
    .rx_acc_real(re), .rx_acc_imag(im),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_ovr(tx_ovr));

  b1_meas_frame #(.NUM_CH(5), .PHS_W(13), .ACC_W(20)) dut5 (
    .rx_clk(clk), .rx_rst_n(rx_rst_n), .rx_pps(rx_pps5),
    .rx_car_nco(car5), .rx_prn_nco(prn5), .rx_prn_phs(phs5),
    .rx_acc_real(re5), .rx_acc_imag(im5),
    .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(1'b1),
    .tx_busy(tx_busy5), .tx_ovr(tx_ovr5));

  int checks = 0, failures = 0;
  logic [7:0] cap[$], cap5[$], exp_q[$];
  int cap_rd = 0, cap5_rd = 0, last_base = 0;
  int ovr_cnt = 0, stab_err = 0;
  bit rnd_ready = 0;
  logic [7:0] seq_exp = 8'h00;

  logic [31:0] mcar[5], mprn[5];
  logic [15:0] mphs[5];
  longint      mre[5], mim[5];

  typedef struct {
    logic [31:0] car0;
    logic [23:0] re0;
    logic [31:0] exp_car;
    logic [23:0] exp_re;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitors sample at negedge; a byte seen with valid&ready is accepted at the next posedge.
  initial begin
    bit stall_prev = 0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rx_rst_n) stall_prev = 0;
      else begin
        if (stall_prev && (!tx_valid || tx_data !== prev_data)) stab_err++;
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        if (tx_ovr) ovr_cnt++;
      end
      if (tx_valid5) cap5.push_back(tx_data5);
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic longint sext(input logic [31:0] v, input int w);
    longint x;
    x = longint'(v & ((32'd1 << w) - 32'd1));
    if (v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  task automatic rand_inputs(input int nch, input int phsw, input int accw);
    for (int c = 0; c < nch; c++) begin
      mcar[c] = $urandom;
      mprn[c] = $urandom;
      mphs[c] = 16'($urandom_range(0, (1 << phsw) - 1));
      mre[c]  = sext($urandom, accw);
      mim[c]  = sext($urandom, accw);
    end
  endtask

  task automatic apply_dut();
    for (int c = 0; c < 2; c++) begin
      car[c*32 +: 32] = mcar[c];
      prn[c*32 +: 32] = mprn[c];
      phs[c*12 +: 12] = 12'(mphs[c]);
      re[c*24 +: 24]  = 24'(mre[c]);
      im[c*24 +: 24]  = 24'(mim[c]);
    end
  endtask

  task automatic apply5();
    for (int c = 0; c < 5; c++) begin
      car5[c*32 +: 32] = mcar[c];
      prn5[c*32 +: 32] = mprn[c];
      phs5[c*13 +: 13] = 13'(mphs[c]);
      re5[c*20 +: 20]  = 20'(mre[c]);
      im5[c*20 +: 20]  = 20'(mim[c]);
    end
  endtask

  function automatic void push_field(input longint v, input int w);
    for (int b = (w + 7) / 8 - 1; b >= 0; b--) exp_q.push_back(8'(v >>> (8 * b)));
  endfunction

  // Expected frame from the layout rules: header, channel fields MSB first, XOR checksum.
  function automatic void build_exp(input int nch, input int phsw, input int accw,
                                    input logic [7:0] s, input bit ovr);
    logic [7:0] x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(s);
    exp_q.push_back({7'(nch), ovr});
    for (int c = 0; c < nch; c++) begin
      push_field(longint'(mcar[c]), 32);
      push_field(longint'(mprn[c]), 32);
      push_field(longint'(mphs[c]), phsw);
      push_field(mre[c], accw);
      push_field(mim[c], accw);
    end
    for (int i = 2; i < exp_q.size(); i++) x ^= exp_q[i];
    exp_q.push_back(x);
  endfunction

  task automatic wait_cmp(input string nm, input bit five);
    int n = exp_q.size();
    int t = 0;
    int avail;
    int bad = -1;
    avail = five ? cap5.size() - cap5_rd : cap.size() - cap_rd;
    while (avail < n && t < 3000) begin
      @(posedge clk); t++;
      avail = five ? cap5.size() - cap5_rd : cap.size() - cap_rd;
    end
    checks++;
    last_base = five ? cap5_rd : cap_rd;
    if (avail < n) begin
      failures++;
      $display("FAIL %s timeout bytes=%0d need=%0d", nm, avail, n);
    end else begin
      for (int i = 0; i < n && bad < 0; i++)
        if ((five ? cap5[last_base + i] : cap[last_base + i]) !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s byte %0d act=%h exp=%h", nm, bad,
                 five ? cap5[last_base + bad] : cap[last_base + bad], exp_q[bad]);
      end
    end
    if (five) cap5_rd = cap5.size(); else cap_rd = last_base + ((avail < n) ? avail : n);
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse();
    @(posedge clk); #2 rx_pps = 1'b1;
    repeat (3) @(posedge clk);
    #2 rx_pps = 1'b0;
  endtask

  task automatic run_frame(input string nm, input bit ovr);
    rand_inputs(2, 12, 24);
    apply_dut();
    build_exp(2, 12, 24, seq_exp, ovr);
    pulse();
    wait_cmp(nm, 1'b0);
    seq_exp++;
  endtask

  task automatic wait_bytes(input string nm, input int n);
    int t = 0;
    while (cap.size() - cap_rd < n && t < 2000) begin @(posedge clk); t++; end
    if (cap.size() - cap_rd < n) begin
      checks++; failures++;
      $display("FAIL %s timeout bytes=%0d need=%0d", nm, cap.size() - cap_rd, n);
    end
  endtask

  initial begin
    int ob, sb;
    tbl[0] = '{32'h12345678, 24'hFFFFFE, 32'h12345678, 24'hFFFFFE};
    tbl[1] = '{32'h00000000, 24'h7FFFFF, 32'h00000000, 24'h7FFFFF};
    tbl[2] = '{32'hFFFFFFFF, 24'h800000, 32'hFFFFFFFF, 24'h800000};

    rx_rst_n = 1'b0; rx_pps = 1'b0; rx_pps5 = 1'b0;
    car = '0; prn = '0; phs = '0; re = '0; im = '0;
    car5 = '0; prn5 = '0; phs5 = '0; re5 = '0; im5 = '0;
    repeat (3) @(posedge clk); #2;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovr", tx_ovr, 0);
    rx_rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Latency and layout on table row 0, then the remaining rows.
    for (int r = 0; r < 3; r++) begin
      rand_inputs(2, 12, 24);
      mcar[0] = tbl[r].car0;
      mre[0]  = sext(32'(tbl[r].re0), 24);
      apply_dut();
      build_exp(2, 12, 24, seq_exp, 1'b0);
      if (r == 0) begin
        @(posedge clk); #2 rx_pps = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("lat_pre_valid", tx_valid, 0);
        rx_pps = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("lat_valid", tx_valid, 1);
        chk("lat_a5", tx_data, 8'hA5);
        chk("lat_busy", tx_busy, 1);
      end else pulse();
      wait_cmp("tbl_frame", 1'b0);
      seq_exp++;
      chk("tbl_car", {cap[last_base+4], cap[last_base+5], cap[last_base+6], cap[last_base+7]},
          tbl[r].exp_car);
      chk("tbl_re", {cap[last_base+14], cap[last_base+15], cap[last_base+16]}, 32'(tbl[r].exp_re));
      if (r == 0) begin
        chk("first_seq", cap[last_base+2], 8'h00);
        chk("first_flags", cap[last_base+3], 8'h04);
      end
    end

    // Back-to-back: second PPS edge lands on the CSUM handshake.
    ob = ovr_cnt;
    rand_inputs(2, 12, 24); apply_dut();
    build_exp(2, 12, 24, seq_exp, 1'b0);
    @(posedge clk); #2 rx_pps = 1'b1;
    repeat (3) @(posedge clk); #2 rx_pps = 1'b0;
    repeat (2) @(posedge clk);
    rand_inputs(2, 12, 24); apply_dut();
    repeat (33) @(posedge clk);
    #2 rx_pps = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b2b_valid", tx_valid, 1);
    chk("b2b_a5", tx_data, 8'hA5);
    rx_pps = 1'b0;
    wait_cmp("b2b_f0", 1'b0);
    seq_exp++;
    build_exp(2, 12, 24, seq_exp, 1'b0);
    wait_cmp("b2b_f1", 1'b0);
    seq_exp++;
    chk("b2b_no_ovr", ovr_cnt - ob, 0);

    // Random backpressure.
    rnd_ready = 1;
    sb = stab_err;
    for (int i = 0; i < 6; i++) run_frame("bp_frame", 1'b0);
    rnd_ready = 0;
    chk("bp_stable", stab_err - sb, 0);

    // Overrun at byte 10; the frame in flight must keep its original snapshot.
    ob = ovr_cnt;
    rand_inputs(2, 12, 24); apply_dut();
    build_exp(2, 12, 24, seq_exp, 1'b0);
    pulse();
    wait_bytes("ovr_wait", 10);
    rand_inputs(2, 12, 24); apply_dut();
    pulse();
    wait_cmp("ovr_f0", 1'b0);
    seq_exp++;
    chk("ovr_pulses", ovr_cnt - ob, 1);
    run_frame("ovr_f1", 1'b1);
    chk("ovr_flags1", cap[last_base+3], 8'h05);
    run_frame("ovr_f2", 1'b0);
    chk("ovr_flags2", cap[last_base+3], 8'h04);

    // Reset in the middle of a frame.
    rand_inputs(2, 12, 24); apply_dut();
    pulse();
    wait_bytes("rst_wait", 20);
    @(posedge clk); #2 rx_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ovr", tx_ovr, 0);
    repeat (3) @(posedge clk); #2 rx_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    cap_rd = cap.size();
    seq_exp = 8'h00;
    run_frame("post_rst", 1'b0);
    chk("post_rst_seq", cap[last_base+2], 8'h00);

    // Sequence wrap.
    for (int i = 0; i < 257; i++) begin
      logic [7:0] s;
      s = seq_exp;
      run_frame("wrap_frame", 1'b0);
      if (s == 8'hFF) chk("wrap_ff", cap[last_base+2], 8'hFF);
      if (s == 8'h00) chk("wrap_00", cap[last_base+2], 8'h00);
    end

    // Five channels, 13-bit phase, 20-bit accumulators.
    rand_inputs(5, 13, 20);
    mphs[0] = 16'h1ABC;
    mre[0]  = -3;
    apply5();
    build_exp(5, 13, 20, 8'h00, 1'b0);
    @(posedge clk); #2 rx_pps5 = 1'b1;
    repeat (3) @(posedge clk); #2 rx_pps5 = 1'b0;
    wait_cmp("five_frame", 1'b1);
    chk("five_flags", cap5[last_base+3], 8'h0A);
    chk("five_phs", {cap5[last_base+12], cap5[last_base+13]}, 32'h1ABC);
    chk("five_re", {cap5[last_base+14], cap5[last_base+15], cap5[last_base+16]}, 32'hFFFFFD);
    repeat (20) @(posedge clk);
    chk("five_len", cap5.size() - last_base, 85);
    #1;
    chk("five_idle", {tx_valid5, tx_busy5, tx_ovr5}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
